// File: rtl/seg7_pkg.sv
// Shared types and constants for the multi-digit seven-segment driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a.
    localparam logic [6:0] SEG_0     = ~7'b0111111;
    localparam logic [6:0] SEG_1     = ~7'b0000110;
    localparam logic [6:0] SEG_2     = ~7'b1011011;
    localparam logic [6:0] SEG_3     = ~7'b1001111;
    localparam logic [6:0] SEG_4     = ~7'b1100110;
    localparam logic [6:0] SEG_5     = ~7'b1101101;
    localparam logic [6:0] SEG_6     = ~7'b1111101;
    localparam logic [6:0] SEG_7     = ~7'b0000111;
    localparam logic [6:0] SEG_8     = ~7'b1111111;
    localparam logic [6:0] SEG_9     = ~7'b1101111;
    localparam logic [6:0] SEG_A     = ~7'b1110111;
    localparam logic [6:0] SEG_B     = ~7'b1111100;
    localparam logic [6:0] SEG_C     = ~7'b0111001;
    localparam logic [6:0] SEG_D     = ~7'b1011110;
    localparam logic [6:0] SEG_E     = ~7'b1111001;
    localparam logic [6:0] SEG_F     = ~7'b1110001;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Number of BCD digits needed so that a w-bit binary value never loses bits.
    function automatic int bcd_digits(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/seg7_nibble_enc.sv
// Combinational 4-bit to active-low seven-segment encoder (0-9, A-F).
module seg7_nibble_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Full sixteen-entry lookup; decimal digits simply never reach A-F.
    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_multi_digit_ctrl.sv
// Multi-digit seven-segment driver: sequential binary-to-BCD (shift-add-3)
// or hex pass-through, with leading-zero blanking and overflow dashes.
module seg7_multi_digit_ctrl #(
    parameter int DIGITS = 4,
    parameter int IN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    input  logic                  in_hex,
    input  logic                  in_blank_lz,
    output logic [7*DIGITS-1:0]   seg_n,
    output logic                  ovf,
    output logic                  done
);
    import seg7_pkg::*;

    localparam int NB = bcd_digits(IN_W);
    localparam int BW = 4 * NB;
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [BW-1:0]          bcd_reg, bcd_next;
    logic [IN_W-1:0]        val_reg, val_next;
    logic                   hex_reg, hex_next;
    logic                   blz_reg, blz_next;
    logic [7*DIGITS-1:0]    seg_n_reg, seg_n_next;
    logic                   ovf_reg, ovf_next;
    logic                   done_reg, done_next;

    logic [BW-1:0]          bcd_adj;
    logic [DW+BW-1:0]       bcd_ext;
    logic [DW+IN_W-1:0]     hex_ext;
    logic [DW-1:0]          shown;
    logic                   ovf_calc;
    logic [DIGITS-1:0]      nz_from;
    logic [7*DIGITS-1:0]    enc_seg;
    logic [7*DIGITS-1:0]    seg_disp;

    // Add-3 correction for every BCD nibble that would exceed 9 after the shift.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Zero-extend both sources above the displayed width so the overflow
    // slices exist for every legal DIGITS/IN_W combination.
    assign bcd_ext  = {{DW{1'b0}}, bcd_reg};
    assign hex_ext  = {{DW{1'b0}}, val_reg};
    assign shown    = hex_reg ? hex_ext[DW-1:0] : bcd_ext[DW-1:0];
    assign ovf_calc = hex_reg ? (|hex_ext[DW+IN_W-1:DW]) : (|bcd_ext[DW+BW-1:DW]);

    // Per-digit encode plus blank/dash selection.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            seg7_nibble_enc u_enc (
                .nibble (shown[4*gi +: 4]),
                .seg_n  (enc_seg[7*gi +: 7])
            );

            // Any nonzero digit at this position or above keeps this digit lit.
            assign nz_from[gi] = |shown[DW-1:4*gi];

            if (gi == 0) begin : g_lsd
                assign seg_disp[6:0] = ovf_calc ? SEG_DASH : enc_seg[6:0];
            end else begin : g_upper
                assign seg_disp[7*gi +: 7] = ovf_calc                 ? SEG_DASH  :
                                             (blz_reg && !nz_from[gi]) ? SEG_BLANK :
                                             enc_seg[7*gi +: 7];
            end
        end
    endgenerate

    // State and datapath registers; reset aborts any conversion and blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
            val_reg   <= '0;
            hex_reg   <= 1'b0;
            blz_reg   <= 1'b0;
            seg_n_reg <= {DIGITS{SEG_BLANK}};
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
            val_reg   <= val_next;
            hex_reg   <= hex_next;
            blz_reg   <= blz_next;
            seg_n_reg <= seg_n_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
        end
    end

    // Next-state and datapath control: accept in IDLE, shift in CONV, publish in LOAD.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;
        val_next   = val_reg;
        hex_next   = hex_reg;
        blz_next   = blz_reg;
        seg_n_next = seg_n_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    val_next = in_value;
                    hex_next = in_hex;
                    blz_next = in_blank_lz;
                    if (in_hex) begin
                        state_next = LOAD;
                    end else begin
                        bcd_next   = '0;
                        cnt_next   = CW'(IN_W);
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                bcd_next = {bcd_adj[BW-2:0], val_reg[IN_W-1]};
                val_next = {val_reg[IN_W-2:0], 1'b0};
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                seg_n_next = seg_disp;
                ovf_next   = ovf_calc;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state_reg == IDLE);
    assign seg_n    = seg_n_reg;
    assign ovf      = ovf_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_seg7_multi_digit_ctrl.sv
// Scoreboard bench for seg7_multi_digit_ctrl (DIGITS=4, IN_W=16).
module tb_seg7_multi_digit_ctrl;
    localparam int DIGITS = 4;
    localparam int IN_W   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic        in_hex = 1'b0;
    logic        in_blank_lz = 1'b0;
    logic [27:0] seg_n;
    logic        ovf;
    logic        done;

    seg7_multi_digit_ctrl #(.DIGITS(DIGITS), .IN_W(IN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_hex      (in_hex),
        .in_blank_lz (in_blank_lz),
        .seg_n       (seg_n),
        .ovf         (ovf),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [27:0] seg;
        logic        ovf;
        int          due;
        int          v;
        bit          hex;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Active-low glyph for a digit value, straight from the segment table.
    function automatic logic [6:0] glyph(input int n);
        logic [6:0] p;
        case (n)
            0: p = 7'b0111111;  1: p = 7'b0000110;  2: p = 7'b1011011;  3: p = 7'b1001111;
            4: p = 7'b1100110;  5: p = 7'b1101101;  6: p = 7'b1111101;  7: p = 7'b0000111;
            8: p = 7'b1111111;  9: p = 7'b1101111; 10: p = 7'b1110111; 11: p = 7'b1111100;
           12: p = 7'b0111001; 13: p = 7'b1011110; 14: p = 7'b1111001; default: p = 7'b1110001;
        endcase
        return ~p;
    endfunction

    // Reference: digits by division (decimal) or shifting (hex); returns {ovf, seg}.
    function automatic logic [28:0] model(input int v, input bit hex, input bit blz);
        int d[DIGITS];
        int msd = 0;
        int pw  = 1;
        logic o;
        logic [27:0] s;
        o = hex ? ((v >> (4 * DIGITS)) != 0) : (v >= 10000);
        for (int k = 0; k < DIGITS; k++) begin
            d[k] = hex ? ((v >> (4 * k)) & 15) : ((v / pw) % 10);
            pw = pw * 10;
            if (d[k] != 0) msd = k;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (o)                 s[7*k +: 7] = 7'h3F;
            else if (blz && k > msd) s[7*k +: 7] = 7'h7F;
            else                   s[7*k +: 7] = glyph(d[k]);
        end
        return {o, s};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                $display("txn value=%0d hex=%0b seg_n=%07h ovf=%0b cyc=%0d",
                         mon_e.v, mon_e.hex, seg_n, ovf, cyc);
                chk("seg_n", 64'(seg_n), 64'(mon_e.seg));
                chk("ovf", 64'(ovf), 64'(mon_e.ovf));
                chk("done_latency", 64'(cyc), 64'(mon_e.due));
                chk("ready_with_done", 64'(in_ready), 64'd1);
            end
        end
    end

    // Issue one transfer; returns the edge count at which it was accepted.
    task automatic send(input int v, input bit hex, input bit blz, output int e0);
        int guard = 0;
        logic [28:0] r;
        e0 = -1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid    = 1'b1;
        in_value    = 16'(v);
        in_hex      = hex;
        in_blank_lz = blz;
        @(posedge clk);
        #1;
        e0 = cyc;
        r  = model(v, hex, blz);
        sbq.push_back('{seg: r[27:0], ovf: r[28], due: cyc + (hex ? 1 : IN_W + 1), v: v, hex: hex});
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sbq.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0a, e0b, lows;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_seg_n", 64'(seg_n), 64'hFFFFFFF);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // 1234 with busy check and an ignored request mid-conversion.
        send(1234, 1'b0, 1'b0, e0a);
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!in_ready) lows++;
            if (i == 5) begin
                in_valid = 1'b1;
                in_value = 16'd42;
                in_hex   = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("busy_ready_low", 64'(lows), 64'd16);
        wait_idle();

        send(5, 1'b0, 1'b1, e0a);
        send(0, 1'b0, 1'b1, e0a);
        send(10000, 1'b0, 1'b0, e0a);
        send(9999, 1'b0, 1'b0, e0a);
        send(16'hBEEF, 1'b1, 1'b0, e0a);
        wait_idle();

        // Back-to-back: second transfer must land on the first in_ready edge.
        send(1234, 1'b0, 1'b0, e0a);
        send(77, 1'b0, 1'b1, e0b);
        chk("b2b_dec_accept", 64'(e0b - e0a), 64'(IN_W + 2));
        send(16'h00A5, 1'b1, 1'b1, e0a);
        send(16'h0F00, 1'b1, 1'b0, e0b);
        chk("b2b_hex_accept", 64'(e0b - e0a), 64'd2);
        wait_idle();

        // Reset mid-conversion: display blanks at once and no done follows.
        send(4321, 1'b0, 1'b0, e0a);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_seg_n", 64'(seg_n), 64'hFFFFFFF);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_rst_seg_n", 64'(seg_n), 64'hFFFFFFF);

        // Randomised mix of modes, blanking and value ranges.
        for (int i = 0; i < 40; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                            : int'($urandom_range(0, 65535));
            send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e0a);
            if ($urandom_range(0, 4) == 0) wait_idle();
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
